lc2k_fetch_unit: RTL and testbench

Instruction fetch and field-decode stage of the LC2K CPU, directly upstream of the control ROM. It owns the program counter, fetches 32-bit instruction words from instruction memory over a req/ready handshake, and holds the opcode and register/offset fields stable for the control ROM and datapath. It holds each instruction until the datapath reports completion, then advances to PC+1 or to a branch/JALR target. It stops permanently after a completed HALT.

---
 rtl/lc2k_fetch_unit.sv | 104 ++++++++++
 tb/tb_lc2k_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_fetch_unit.sv
// LC2K instruction fetch and field-decode stage.
// Owns the PC, fetches one instruction word at a time over a req/ready
// handshake, and holds the decoded fields until the datapath retires the
// instruction. It stops for good after a retired HALT (until reset).
module lc2k_fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  input  logic                exec_done,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  output logic [2:0]          opcode,
  output logic [2:0]          reg_a,
  output logic [2:0]          reg_b,
  output logic [2:0]          dest_reg,
  output logic [31:0]         offset_ext,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                halted,
  output logic [31:0]         instr_count
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [2:0] OP_HALT = 3'b110;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         cnt_q, cnt_d;

  logic fetch_hit;
  logic retire;
  logic is_halt;

  assign fetch_hit = (state_q == S_FETCH) && imem_ready;
  assign retire    = (state_q == S_ISSUE) && exec_done;
  assign is_halt   = (ir_q[24:22] == OP_HALT);
  assign pc_plus1  = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // State register: async reset lands in FETCH at RESET_PC with a cleared IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: FETCH -> ISSUE on ready, ISSUE -> FETCH/HALTED on retire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_ISSUE;
      S_ISSUE:  if (exec_done)  state_d = is_halt ? S_HALTED : S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath updates: IR loads on a completed fetch; PC and count move on retire.
  // A retiring HALT leaves the PC where it is and ignores any redirect.
  always_comb begin
    ir_d  = fetch_hit ? imem_rdata : ir_q;
    cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
    pc_d  = pc_q;
    if (retire && !is_halt)
      pc_d = redirect_valid ? redirect_pc : pc_plus1;
  end

  // Outputs: request is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    imem_req    = rst_n && (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    halted      = (state_q == S_HALTED);
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_count = cnt_q;
  assign opcode      = ir_q[24:22];
  assign reg_a       = ir_q[21:19];
  assign reg_b       = ir_q[18:16];
  assign dest_reg    = ir_q[2:0];
  assign offset_ext  = {{16{ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_lc2k_fetch_unit.sv
// Bench for lc2k_fetch_unit: directed test-plan items plus a randomized
// instruction stream, checked against a transaction-level model of
// PC / instruction count / halt behaviour.
module tb_lc2k_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [2:0]  opcode, reg_a, reg_b, dest_reg;
  logic [31:0] offset_ext;
  logic [15:0] pc_out, pc_plus1;
  logic        halted;
  logic [31:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int unsigned m_pc;
  int unsigned m_cnt;
  bit          m_halt;
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  lc2k_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .exec_done(exec_done), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .opcode(opcode), .reg_a(reg_a), .reg_b(reg_b),
    .dest_reg(dest_reg), .offset_ext(offset_ext), .pc_out(pc_out), .pc_plus1(pc_plus1),
    .halted(halted), .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Expected decode of a word, from the ISA field positions.
  task automatic chk_fields(input logic [31:0] w);
    int unsigned lo;
    lo = w & 32'hFFFF;
    chk("opcode",   {29'd0, opcode},   (w >> 22) & 7);
    chk("reg_a",    {29'd0, reg_a},    (w >> 19) & 7);
    chk("reg_b",    {29'd0, reg_b},    (w >> 16) & 7);
    chk("dest_reg", {29'd0, dest_reg}, w & 7);
    chk("offset_ext", offset_ext, (lo >= 32768) ? lo + 32'hFFFF0000 : lo);
    chk("pc_out",   {16'd0, pc_out},   m_pc);
    chk("pc_plus1", {16'd0, pc_plus1}, (m_pc + 1) % 65536);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; imem_ready = 1'b0; exec_done = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_addr", {16'd0, imem_addr}, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_opcode", {29'd0, opcode}, 0);
    chk("rst_offset", offset_ext, 0);
    chk("rst_count", instr_count, 0);
    tick();
    rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_halt = 0;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 1);
  endtask

  // Serve one fetch with lat wait cycles, then check the decoded fields.
  task automatic do_fetch(input logic [31:0] w, input int lat);
    int n = 0;
    while (!imem_req && n < 50) begin tick(); n++; end
    chk("req_seen", {31'd0, imem_req}, 1);
    chk("imem_addr", {16'd0, imem_addr}, m_pc);
    for (int i = 0; i < lat; i++) begin
      imem_ready = 1'b0; imem_rdata = $urandom;
      exec_done = $urandom_range(0, 1);  // ignored outside ISSUE
      tick();
      chk("req_hold", {31'd0, imem_req}, 1);
      chk("addr_hold", {16'd0, imem_addr}, m_pc);
      chk("valid_low", {31'd0, instr_valid}, 0);
    end
    exec_done = 1'b0;
    imem_ready = 1'b1; imem_rdata = w;
    tick();
    imem_ready = 1'b0; imem_rdata = $urandom;
    m_ir = w;
    chk("instr_valid", {31'd0, instr_valid}, 1);
    chk_fields(w);
  endtask

  // Hold the instruction for hold cycles, then retire it.
  task automatic do_exec(input int hold, input bit rv, input logic [15:0] rpc);
    for (int i = 0; i < hold; i++) begin
      imem_ready = $urandom_range(0, 1);  // ignored outside FETCH
      imem_rdata = $urandom;
      tick();
      chk("held_valid", {31'd0, instr_valid}, 1);
      chk_fields(m_ir);
    end
    imem_ready = 1'b0;
    exec_done = 1'b1; redirect_valid = rv; redirect_pc = rpc;
    tick();
    exec_done = 1'b0; redirect_valid = 1'b0; redirect_pc = $urandom;
    m_cnt++;
    if (((m_ir >> 22) & 7) == 6) m_halt = 1;
    else m_pc = rv ? rpc : (m_pc + 1) % 65536;
    chk("instr_count", instr_count, m_cnt);
    chk("pc_after", {16'd0, pc_out}, m_pc);
    chk("halted", {31'd0, halted}, m_halt);
    chk("req_after", {31'd0, imem_req}, !m_halt);
    chk("valid_after", {31'd0, instr_valid}, 0);
  endtask

  initial begin
    logic [31:0] w;
    imem_rdata = 32'd0; redirect_pc = 16'd0;
    reset_dut();

    // add 1 2 3, then redirect to 5
    do_fetch(32'h000A0003, 0);
    do_exec(1, 1'b1, 16'h0005);
    // lw 0 1 -1, held 4 cycles, fall through to 6
    do_fetch(32'h0081FFFF, 2);
    do_exec(4, 1'b0, 16'h1234);
    chk("pc_is_6", {16'd0, imem_addr}, 6);
    chk("count_is_2", instr_count, 2);

    // PC wrap at the top of the address space
    do_fetch(32'h00000000, 0);
    do_exec(0, 1'b1, 16'hFFFF);
    do_fetch(32'h01C00000, 1);  // noop behaves as a plain instruction
    chk("plus1_wrap", {16'd0, pc_plus1}, 0);
    do_exec(1, 1'b0, 16'h0042);
    chk("wrap_addr", {16'd0, imem_addr}, 0);

    // randomized stream of non-halt instructions
    for (int k = 0; k < 80; k++) begin
      w = $urandom;
      if (w[24:22] == 3'b110) w[22] = 1'b1;
      do_fetch(w, $urandom_range(0, 3));
      do_exec($urandom_range(0, 3), 1'(($urandom & 1) != 0),
              ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
    end

    // halt with a redirect that must be ignored
    do_fetch(32'h01800000, 1);
    do_exec(2, 1'b1, 16'h4321);
    for (int i = 0; i < 20; i++) begin
      imem_ready = $urandom_range(0, 1); exec_done = $urandom_range(0, 1);
      redirect_valid = 1'b1; redirect_pc = $urandom;
      tick();
      chk("halt_req", {31'd0, imem_req}, 0);
      chk("halt_valid", {31'd0, instr_valid}, 0);
      chk("halt_flag", {31'd0, halted}, 1);
    end
    imem_ready = 1'b0; exec_done = 1'b0; redirect_valid = 1'b0;
    chk("halt_count", instr_count, m_cnt);
    chk("halt_pc", {16'd0, pc_out}, m_pc);

    // reset in the middle of a fetch at 0x0010
    reset_dut();
    do_fetch(32'h00110007, 0);
    do_exec(1, 1'b1, 16'h0010);
    chk("mid_req", {31'd0, imem_req}, 1);
    chk("mid_addr", {16'd0, imem_addr}, 16'h0010);
    #2;
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("async_req", {31'd0, imem_req}, 0);
    chk("async_addr", {16'd0, imem_addr}, 0);
    tick();
    tick();
    chk("rst_ir_opcode", {29'd0, opcode}, 0);
    chk("rst_ir_offset", offset_ext, 0);
    chk("rst_ir_valid", {31'd0, instr_valid}, 0);
    chk("rst_ir_count", instr_count, 0);
    imem_ready = 1'b0;
    rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_halt = 0;
    #1;
    do_fetch(32'h000A0003, 0);
    do_exec(0, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
